mod_dn_cntr: RTL
================

Name: mod_dn_cntr

Overview:
- Loadable, programmable-modulus down counter with start/enable control and a terminal-count (borrow) output.
- It is the count-down counterpart of the team's up-counting modulo counter. It serves as a timeout/interval generator, and `tc` can be cascaded into another counter's `en`.
- Two modes: auto-reload (periodic) and one-shot (stops at 0 and flags `done`).

Parameters:
- MOD, 16, default modulus; count range MOD-1 down to 0; MOD >= 2.
- W, $clog2(MOD), counter width; derived from MOD, not overridden.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  begin or restart counting from the reload value.
- en  input  1  count enable; one decrement per cycle while high in RUN.
- load  input  1  load a new reload value.
- load_val  input  W  reload value; saturated to MOD-1 if >= MOD.
- oneshot  input  1  0 = auto-reload, 1 = one-shot; sampled every cycle.
- z  output  W  current count (registered).
- tc  output  1  terminal count, combinational: (state==RUN) & en & (z==0) & ~load.
- busy  output  1  high in RUN (registered).
- done  output  1  high in DONE (registered).

Behaviour:
- Reset (rst=0 at a clock edge):
  - z = MOD-1, rld = MOD-1, state = IDLE, busy = 0, done = 0.
  - tc = 0 (follows from state).
  - Reset mid-count aborts immediately; no tc is issued.
- Internal reload register rld (W bits) holds the value the counter restarts from.
- Saturation rule: sat(v) = (v >= MOD) ? MOD-1 : v.
- Priority each cycle: reset > load > start > count.
- load=1, any state:
  - rld <= sat(load_val) and z <= sat(load_val).
  - State unchanged; start and en are ignored that cycle.
- start=1 (no load), any state:
  - z <= rld, state <= RUN.
  - A restart in RUN is legal and discards the current count.
- States:
  - IDLE: z holds. start -> RUN.
  - RUN, en=0: z holds.
  - RUN, en=1, z!=0: z <= z-1.
  - RUN, en=1, z==0, tc=1, oneshot=0: z <= rld; stay in RUN.
  - RUN, en=1, z==0, tc=1, oneshot=1: z stays 0; state <= DONE.
  - DONE: z holds 0, en ignored. start -> RUN with z <= rld. No automatic exit.
- Timing:
  - Period in auto-reload with en held high is rld+1 cycles between tc pulses.
  - First tc comes rld+1 cycles after the cycle in which start is sampled.
- rld = 0: in auto-reload, tc asserts on every enabled RUN cycle. In one-shot, DONE is entered on the first enabled cycle.
- Arithmetic: the decrement never underflows. The z==0 case is handled by reload/hold, so z is always in [0, MOD-1].
- Outputs z, busy, done come directly from flops; tc is the only combinational output.

Optional Feature:
- Macro: MOD_DN_CNTR_UPDN_EN.
- Defined: adds input port `dir` (1 bit). dir=0 behaves exactly as above. dir=1 counts up:
  - start sets z <= 0.
  - Terminal condition is z==rld, so tc = RUN & en & (z==rld) & ~load.
  - Auto-reload wraps z to 0; one-shot holds z at rld and enters DONE.
  - load sets rld <= sat(load_val) and z <= 0.
  - Period stays rld+1 cycles.
  - Changing dir mid-count takes effect next cycle; the terminal check uses the current dir.
- Not defined: no `dir` port; down-count only.

Test Plan:
- MOD=10, reset then release: z=9, busy=0, done=0, tc=0; z holds 9 in IDLE with en=1 and no start.
- Auto-reload, start pulse, en=1 held: z sequence 9,8,...,0,9,8...; tc high only in cycles where z==0, every 10 cycles; busy=1 throughout.
- One-shot, load_val=3, then start, en=1:
  - z goes 3,2,1,0; tc high for one cycle at z=0.
  - Next cycle done=1, busy=0, z=0 held.
  - A later start returns to RUN with z=3.
- load_val=12 with MOD=10: rld and z become 9 (saturated). load and start in the same cycle: load wins and state is unchanged. en gaps freeze z with no tc.
- Reset asserted while z=4 in RUN: next cycle z=9, IDLE, busy=0, tc=0. load_val=0 in auto-reload: tc high on every enabled cycle.
- With MOD_DN_CNTR_UPDN_EN, dir=1, load_val=5, start, en=1: z goes 0..5 then 0; tc at z=5 every 6 cycles. One-shot holds z=5 with done=1.

Source files
------------

// File: rtl/mod_dn_cntr.sv
// mod_dn_cntr: loadable, programmable-modulus down counter with start/enable
// control, auto-reload or one-shot operation and a terminal-count (borrow)
// output suitable for cascading into another counter's en.
// Optional up/down operation is enabled by defining MOD_DN_CNTR_UPDN_EN,
// which adds the dir input (0 = count down, 1 = count up).
//
// state | meaning
// IDLE  | waiting for start; z holds
// RUN   | counting; one step per cycle while en is high
// DONE  | one-shot expired; z holds until the next start
module mod_dn_cntr #(
  parameter int  MOD = 16,
  localparam int W   = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         oneshot,
`ifdef MOD_DN_CNTR_UPDN_EN
  input  logic         dir,
`endif
  output logic [W-1:0] z,
  output logic         tc,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  state_t       state, state_nxt;
  logic [W-1:0] rld, rld_nxt;
  logic [W-1:0] z_nxt;
  logic [W-1:0] ld_sat;
  logic [W-1:0] base;
  logic [W-1:0] term;
  logic         cnt_up;

`ifdef MOD_DN_CNTR_UPDN_EN
  assign cnt_up = dir;
`else
  assign cnt_up = 1'b0;
`endif

  // Out-of-range reload requests clamp to the largest count.
  assign ld_sat = (int'(load_val) >= MOD) ? TOP : load_val;

  // Counting down restarts from rld and ends at 0; counting up is the mirror.
  assign base = cnt_up ? '0 : rld;
  assign term = cnt_up ? rld : '0;

  // Borrow is masked by load so a reload never emits a spurious pulse.
  assign tc = (state == RUN) & en & (z == term) & ~load;

  // Next-state and next-count: load > start > count.
  always_comb begin
    state_nxt = state;
    z_nxt     = z;
    rld_nxt   = rld;
    if (load) begin
      rld_nxt = ld_sat;
      z_nxt   = cnt_up ? '0 : ld_sat;
    end else if (start) begin
      z_nxt     = base;
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (z == term) begin
              if (oneshot) state_nxt = DONE;
              else         z_nxt     = base;
            end else if (cnt_up) begin
              z_nxt = z + 1'b1;
            end else begin
              z_nxt = z - 1'b1;
            end
          end
        end
        IDLE:    state_nxt = IDLE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, count, reload and status flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      z     <= TOP;
      rld   <= TOP;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      z     <= z_nxt;
      rld   <= rld_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

endmodule
